// File: rtl/timer_pkg.sv
// Shared types and sizing for the game countdown timer.
package timer_pkg;

    localparam int MAX_SEC_DEF = 99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    function automatic int count_width(input int max_sec);
        return $clog2(max_sec + 1);
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the slow 1 Hz square wave into the clk_in domain and emits a
// single-cycle pulse per rising edge.
module tick_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_out = sync_q & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable seconds countdown driven by a synchronized 1 Hz tick, with BCD
// digits for the display and an expiry pulse/level for the game FSM.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int CW      = count_width(MAX_SEC)
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          sec_clk,
    input  logic          load,
    input  logic [CW-1:0] load_sec,
    input  logic          start,
    input  logic          pause,
    output logic [CW-1:0] secs_left,
    output logic [3:0]    tens,
    output logic [3:0]    ones,
    output logic          running,
    output logic          expired,
    output logic          done
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SEC);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] TEN     = CW'(10);

    state_e        state_q, state_d;
    logic [CW-1:0] secs_q, secs_d;
    logic          expired_q, expired_d;
    logic          running_q;
    logic          done_q;
    logic          tick;

    tick_sync u_tick_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .async_in  (sec_clk),
        .pulse_out (tick)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            secs_q    <= '0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            secs_q    <= secs_d;
            expired_q <= expired_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == EXPIRED);
        end
    end

    // Priority: load > pause > start > tick, in every state.
    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        expired_d = 1'b0;
        if (load) begin
            secs_d  = (load_sec > MAX_CNT) ? MAX_CNT : load_sec;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!pause && start) begin
                        if (secs_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d   = EXPIRED;
                            expired_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        if (secs_q > ONE) begin
                            secs_d = secs_q - ONE;
                        end else begin
                            secs_d    = '0;
                            state_d   = EXPIRED;
                            expired_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    secs_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign secs_left = secs_q;
    assign tens      = 4'(secs_q / TEN);
    assign ones      = 4'(secs_q % TEN);
    assign running   = running_q;
    assign expired   = expired_q;
    assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a cycle-level
// behavioural model of the timer rules.
module tb_countdown_timer;

    localparam int MAXS = 99;
    localparam int CW   = 7;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          sec_clk;
    logic          load;
    logic [CW-1:0] load_sec;
    logic          start;
    logic          pause;
    logic [CW-1:0] secs_left;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          running;
    logic          expired;
    logic          done;

    countdown_timer #(.MAX_SEC(MAXS), .CW(CW)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .sec_clk   (sec_clk),
        .load      (load),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .secs_left (secs_left),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .expired   (expired),
        .done      (done)
    );

    always #10 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: seconds remaining, mode, expiry pulse, and the last
    // three sec_clk values seen at clock edges (newest first).
    int m_cnt;
    int m_mode;
    int m_exp;
    bit s_hist [3];
    int exp_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_mode = M_IDLE;
        m_exp  = 0;
        for (int i = 0; i < 3; i++) s_hist[i] = 1'b0;
    endtask

    // A rising edge of sec_clk becomes visible to the count two edges after
    // it is first sampled.
    task automatic model_edge();
        bit tk;
        tk    = s_hist[1] & ~s_hist[2];
        m_exp = 0;
        if (load) begin
            m_cnt  = (int'(load_sec) > MAXS) ? MAXS : int'(load_sec);
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (!pause && start) begin
                if (m_cnt > 0) m_mode = M_RUN;
                else begin m_mode = M_EXP; m_exp = 1; end
            end
        end else if (m_mode == M_RUN) begin
            if (pause) m_mode = M_PAUSE;
            else if (tk) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin m_mode = M_EXP; m_exp = 1; end
            end
        end else if (m_mode == M_PAUSE) begin
            if (!pause && start) m_mode = M_RUN;
        end
        s_hist[2] = s_hist[1];
        s_hist[1] = s_hist[0];
        s_hist[0] = sec_clk;
    endtask

    task automatic check_outputs();
        chk("secs_left", 32'(secs_left), 32'(m_cnt));
        chk("tens", 32'(tens), 32'(m_cnt / 10));
        chk("ones", 32'(ones), 32'(m_cnt % 10));
        chk("running", 32'(running), 32'(m_mode == M_RUN));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("done", 32'(done), 32'(m_mode == M_EXP));
        if (expired === 1'b1) exp_seen++;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic strobe_load(input int v);
        load = 1'b1; load_sec = CW'(v);
        cycle();
        load = 1'b0;
    endtask

    task automatic strobe_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic strobe_pause();
        pause = 1'b1; cycle(); pause = 1'b0;
    endtask

    task automatic sec_edges(input int n);
        for (int i = 0; i < n; i++) begin
            sec_clk = 1'b1; repeat (4) cycle();
            sec_clk = 1'b0; repeat (4) cycle();
        end
    endtask

    // Reset asserted away from the clock edge must clear outputs at once.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_secs", 32'(secs_left), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_expired", 32'(expired), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sec_clk = 1'b0; load = 1'b0; load_sec = '0;
        start = 1'b0; pause = 1'b0; exp_seen = 0;
        model_reset();
        #5;
        chk("init_secs", 32'(secs_left), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        cycle();
        $display("step: initial reset released");

        // Reset mid-run at 37 with sec_clk high, then check no decrement.
        strobe_load(40); strobe_start(); sec_edges(3);
        chk("run_at_37", 32'(secs_left), 32'd37);
        sec_clk = 1'b1;
        async_reset();
        repeat (6) cycle();
        chk("post_rst_secs", 32'(secs_left), 32'd0);
        sec_clk = 1'b0;
        $display("step: reset mid-run");

        // Five edges take 5 to 0 with a single expiry pulse; a sixth is inert.
        strobe_load(5); strobe_start();
        exp_seen = 0;
        sec_edges(6);
        chk("five_expired_pulses", 32'(exp_seen), 32'd1);
        chk("five_done", 32'(done), 32'd1);
        chk("five_secs", 32'(secs_left), 32'd0);
        $display("step: count 5 to 0");

        // Clamp to MAX_SEC.
        strobe_load(120);
        chk("clamp_secs", 32'(secs_left), 32'd99);
        chk("clamp_tens", 32'(tens), 32'd9);
        chk("clamp_ones", 32'(ones), 32'd9);
        strobe_start(); sec_edges(1);
        chk("clamp_tick_secs", 32'(secs_left), 32'd98);
        chk("clamp_tick_ones", 32'(ones), 32'd8);
        $display("step: clamp 120 to 99");

        // Pause freezes the count; a tick coinciding with pause is dropped.
        strobe_load(10); strobe_start();
        sec_clk = 1'b1; cycle(); cycle();
        strobe_pause();
        chk("pause_drop_secs", 32'(secs_left), 32'd10);
        sec_clk = 1'b0; repeat (4) cycle();
        sec_edges(3);
        chk("paused_hold", 32'(secs_left), 32'd10);
        strobe_start(); sec_edges(1);
        chk("resume_secs", 32'(secs_left), 32'd9);
        $display("step: pause and resume");

        // Load coinciding with a tick in RUN wins.
        strobe_load(20); strobe_start();
        sec_clk = 1'b1; cycle(); cycle();
        strobe_load(7);
        chk("load_tick_secs", 32'(secs_left), 32'd7);
        chk("load_tick_running", 32'(running), 32'd0);
        sec_clk = 1'b0; repeat (4) cycle();
        $display("step: load beats tick");

        // Start with zero expires immediately; start in EXPIRED is ignored.
        strobe_load(0);
        exp_seen = 0;
        strobe_start();
        chk("zero_expired", 32'(expired), 32'd1);
        strobe_start(); cycle();
        chk("zero_pulses", 32'(exp_seen), 32'd1);
        chk("zero_done", 32'(done), 32'd1);
        strobe_load(3);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_secs", 32'(secs_left), 32'd3);
        $display("step: zero start and reload");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) sec_clk = ~sec_clk;
            load     = ($urandom_range(0, 39) == 0);
            load_sec = CW'($urandom_range(0, 127));
            start    = ($urandom_range(0, 7) == 0);
            pause    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                load = 1'b0; start = 1'b0; pause = 1'b0;
                async_reset();
            end else begin
                cycle();
            end
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;
        $display("step: random traffic done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Game countdown timer; sits directly downstream of the 50 MHz → 1 Hz clock divider and consumes its 1 Hz square wave (clk_out) as a data input on the 50 MHz domain. Never uses it as a clock.
- Holds a loadable seconds count and decrements it once per 1 Hz rising edge while running.
- Exposes BCD digits for the seven-segment display and an expiry flag for the game FSM.

Parameters:
- MAX_SEC, 99, largest loadable count; legal range 1..99 so that BCD is two digits.
- CW, 7, count width, equal to $clog2(MAX_SEC+1).

Ports:
- clk_in  input  1  50 MHz system clock; all state is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sec_clk  input  1  1 Hz square wave from the clock divider; asynchronous to logic, treated as data.
- load  input  1  1-cycle strobe; load load_sec into the count.
- load_sec  input  CW  seconds to load; clamped to MAX_SEC.
- start  input  1  level-sampled strobe; begin or resume counting.
- pause  input  1  strobe; suspend counting.
- secs_left  output  CW  current count.
- tens  output  4  BCD tens digit of secs_left.
- ones  output  4  BCD ones digit of secs_left.
- running  output  1  high in RUN state.
- expired  output  1  1-cycle pulse when the count reaches 0 from RUN.
- done  output  1  level; high in EXPIRED state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, secs_left=0, sync flops=0, running=0, expired=0, done=0.
- Tick generation:
  - sec_clk passes through a 2-flop synchronizer plus a previous-value flop.
  - tick = sync_q & ~prev_q, a 1-cycle pulse.
  - A rising edge of sec_clk produces tick 2–3 clk_in cycles later. Exactly one tick per rising edge; falling edges are ignored.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Priority in every state: rst > load > pause > start > tick.
- load, in any state:
  - secs_left ← min(load_sec, MAX_SEC); state ← IDLE.
  - expired=0; any coincident tick is discarded.
- IDLE:
  - start with secs_left>0 → RUN.
  - start with secs_left==0 → EXPIRED next cycle, with an expired pulse.
  - tick is ignored.
- RUN:
  - tick with secs_left>1 → secs_left−1.
  - tick with secs_left==1 → secs_left=0, state EXPIRED, expired=1 in the same cycle the count becomes 0.
  - pause → PAUSED; a tick in that same cycle is dropped.
- PAUSED:
  - start → RUN.
  - tick is ignored; the count is frozen.
- EXPIRED:
  - done=1, secs_left holds 0.
  - start and pause are ignored; only load or rst leaves this state.
- expired is a registered pulse, high for exactly one cycle per expiry. done is a registered level equal to (state==EXPIRED).
- running is registered and equals (state==RUN).
- tens/ones are combinational from secs_left: tens=secs_left/10, ones=secs_left%10. Never above 9.
- No wrap-around: the count never goes below 0 and never exceeds MAX_SEC.
- Reset mid-count: all state clears immediately, with no partial decrement.

Decomposition:
- Package timer_pkg: state enum (IDLE, RUN, PAUSED, EXPIRED), MAX_SEC default, CW derivation.
- Sub-module tick_sync: 2-flop synchronizer plus rising-edge detector. Ports clk_in, rst, async_in, pulse_out.
- BCD split stays inline.

Test Plan:
- Async reset mid-RUN at secs_left=37 → all outputs 0 and state IDLE within the same cycle; no tick effect after release.
- load_sec=5, start, then 5 sec_clk rising edges → secs_left 5→4→3→2→1→0. expired high exactly one cycle at the 0 transition; done=1 afterwards; a 6th edge leaves secs_left=0.
- load_sec=120 with MAX_SEC=99 → secs_left=99, tens=9, ones=9. One tick in RUN → 98, tens=9, ones=8.
- RUN at 10, pause, 3 sec_clk edges, start, 1 edge → holds 10 while paused, then 9. A tick coincident with pause is dropped.
- load coincident with tick in RUN at 20, load_sec=7 → secs_left=7, state IDLE, no decrement.
- load_sec=0 then start → EXPIRED the next cycle with one expired pulse. start in EXPIRED has no effect; a later load of 3 → IDLE with done=0.
